// File: rtl/sfp_link_reset_ctrl_pkg.sv
// sfp_link_reset_ctrl_pkg: shared FSM state encodings and helpers for the SFP+ lane reset sequencer
package sfp_link_reset_ctrl_pkg;

    localparam logic [2:0] ST_WAIT_GT    = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] ST_UP         = 3'd2;
    localparam logic [2:0] ST_DOWN_HOLD  = 3'd3;
    localparam logic [2:0] ST_RESET      = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sfp_link_reset_ctrl_sync_signal.sv
// sync_signal: N-stage flip-flop synchroniser for WIDTH independent async bits
//   clk  in          destination clock
//   rst  in          async active-high reset, clears every stage
//   d_i  in  WIDTH   asynchronous inputs
//   q_o  out WIDTH   synchronised outputs, N cycles behind d_i (N >= 2)
module sync_signal #(
    parameter int WIDTH = 4,
    parameter int N     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [N-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= {pipe_q[N-2:0], d_i};
    end

    assign q_o = pipe_q[N-1];

endmodule

// File: rtl/sfp_link_reset_ctrl.sv
// sfp_link_reset_ctrl: per-lane 10GBASE-R bring-up/recovery sequencer driving the GT RX datapath reset
//   clk                     in   free-running management clock
//   rst                     in   async active-high reset
//   gt_reset_tx_done_i      in   GT TX reset done (async)
//   gt_reset_rx_done_i      in   GT RX reset done (async)
//   rx_block_lock_i         in   PCS block lock (async)
//   rx_high_ber_i           in   PCS high-BER (async)
//   force_reset_i           in   single-cycle RX datapath reset request (clk domain)
//   gt_rx_datapath_reset_o  out  registered RX datapath reset
//   link_up_o               out  registered, debounced link status
//   retry_count_o           out  saturating count of RX resets issued
//   state_o                 out  current FSM state encoding
module sfp_link_reset_ctrl
    import sfp_link_reset_ctrl_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 1250000,
    parameter int DOWN_HOLD    = 125000,
    parameter int RESET_PULSE  = 16,
    parameter int RETRY_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gt_reset_tx_done_i,
    input  logic                   gt_reset_rx_done_i,
    input  logic                   rx_block_lock_i,
    input  logic                   rx_high_ber_i,
    input  logic                   force_reset_i,
    output logic                   gt_rx_datapath_reset_o,
    output logic                   link_up_o,
    output logic [RETRY_WIDTH-1:0] retry_count_o,
    output logic [2:0]             state_o
);

    localparam int TW = $clog2(max3(LOCK_TIMEOUT, DOWN_HOLD, RESET_PULSE) + 1);

    logic [3:0] sync_s;
    logic tx_done_s, rx_done_s, lock_s, ber_s;

    sync_signal #(.WIDTH(4), .N(2)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({gt_reset_tx_done_i, gt_reset_rx_done_i, rx_block_lock_i, rx_high_ber_i}),
        .q_o (sync_s)
    );

    assign {tx_done_s, rx_done_s, lock_s, ber_s} = sync_s;

    logic [2:0]             state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d, load;
    logic [RETRY_WIDTH-1:0] retry_q, retry_d;
    logic link_up_q, link_up_d, pulse_q, pulse_d, seen_drop_q, seen_drop_d;
    logic good, done, expire, in_link, enter, enter_reset;

    // The timer holds the remaining cycles of the current state and expires
    // on its last cycle (value 1), so a load of D keeps the state for exactly
    // D cycles. Zero only occurs after reset or an idle UP; it reloads.
    always_comb begin
        good    = lock_s & ~ber_s;
        done    = tx_done_s & rx_done_s;
        expire  = timer_q == TW'(1);
        in_link = state_q inside {ST_WAIT_LOCK, ST_UP, ST_DOWN_HOLD};
        case (state_q)
            ST_WAIT_GT:   state_d = (done && !seen_drop_q) ? ST_WAIT_LOCK : expire ? ST_RESET : ST_WAIT_GT;
            ST_WAIT_LOCK: state_d = good ? ST_UP : expire ? ST_RESET : ST_WAIT_LOCK;
            ST_UP:        state_d = good ? ST_UP : ST_DOWN_HOLD;
            ST_DOWN_HOLD: state_d = good ? ST_UP : expire ? ST_WAIT_LOCK : ST_DOWN_HOLD;
            ST_RESET:     state_d = expire ? ST_WAIT_GT : ST_RESET;
            default:      state_d = ST_WAIT_GT;
        endcase
        if (in_link && !done) state_d = ST_WAIT_GT;
        if (force_reset_i) state_d = ST_RESET;
        // A force while already in RESET counts as a fresh entry
        enter       = force_reset_i || (state_d != state_q);
        enter_reset = enter && (state_d == ST_RESET);
        load        = (state_d == ST_DOWN_HOLD) ? TW'(DOWN_HOLD) :
                      (state_d == ST_RESET)     ? TW'(RESET_PULSE) : TW'(LOCK_TIMEOUT);
        timer_d     = (enter || timer_q == '0) ? load : timer_q - TW'(1);
        retry_d     = (enter_reset && retry_q != '1) ? retry_q + RETRY_WIDTH'(1) : retry_q;
        // Blocks re-entry to WAIT_LOCK until rx_done has visibly dropped after our reset
        seen_drop_d = enter_reset ? 1'b1 : !rx_done_s ? 1'b0 : seen_drop_q;
        link_up_d   = state_d inside {ST_UP, ST_DOWN_HOLD};
        pulse_d     = state_d == ST_RESET;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT_GT;
            timer_q     <= '0;
            retry_q     <= '0;
            link_up_q   <= 1'b0;
            pulse_q     <= 1'b0;
            seen_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            link_up_q   <= link_up_d;
            pulse_q     <= pulse_d;
            seen_drop_q <= seen_drop_d;
        end
    end

    assign gt_rx_datapath_reset_o = pulse_q;
    assign link_up_o              = link_up_q;
    assign retry_count_o          = retry_q;
    assign state_o                = state_q;

endmodule

// File: tb/tb_sfp_link_reset_ctrl.sv
// tb_sfp_link_reset_ctrl: directed self-checking bench for the SFP+ lane reset sequencer
module tb_sfp_link_reset_ctrl;
    import sfp_link_reset_ctrl_pkg::*;

    logic clk, rst;
    logic tx_done, rx_done, lock, ber, force_rst;
    logic gt_rst, link_up;
    logic [7:0] retry;
    logic [2:0] state;
    int n_assert, n_fail;

    sfp_link_reset_ctrl #(
        .LOCK_TIMEOUT (100),
        .DOWN_HOLD    (20),
        .RESET_PULSE  (4),
        .RETRY_WIDTH  (8)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .gt_reset_tx_done_i     (tx_done),
        .gt_reset_rx_done_i     (rx_done),
        .rx_block_lock_i        (lock),
        .rx_high_ber_i          (ber),
        .force_reset_i          (force_rst),
        .gt_rx_datapath_reset_o (gt_rst),
        .link_up_o              (link_up),
        .retry_count_o          (retry),
        .state_o                (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [2:0] st, input logic lu);
        chk({tag, " state"}, 32'(state), 32'(st));
        chk({tag, " link_up"}, 32'(link_up), 32'(lu));
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst = 1'b1;
        tx_done = 1'b0; rx_done = 1'b0; lock = 1'b0; ber = 1'b0; force_rst = 1'b0;
        cyc(3);
        chk_st("reset", ST_WAIT_GT, 1'b0);
        chk("reset gt_rst", 32'(gt_rst), 0);
        chk("reset retry", 32'(retry), 0);
        rst = 1'b0;
        tx_done = 1'b1; rx_done = 1'b1;
        cyc(2); chk_st("bringup sync", ST_WAIT_GT, 1'b0);
        cyc(1); chk_st("bringup wait_lock", ST_WAIT_LOCK, 1'b0);
        cyc(47); lock = 1'b1;
        cyc(2); chk_st("lock sync", ST_WAIT_LOCK, 1'b0);
        cyc(1); chk_st("bringup up", ST_UP, 1'b1);
        chk("bringup retry", 32'(retry), 0);
        chk("bringup gt_rst", 32'(gt_rst), 0);
        lock = 1'b0;
        cyc(2); chk_st("drop sync", ST_UP, 1'b1);
        cyc(1); chk_st("drop hold", ST_DOWN_HOLD, 1'b1);
        cyc(19); chk_st("hold last", ST_DOWN_HOLD, 1'b1);
        cyc(1); chk_st("declared down", ST_WAIT_LOCK, 1'b0);
        cyc(99); chk_st("nolock last", ST_WAIT_LOCK, 1'b0);
        chk("nolock gt_rst pre", 32'(gt_rst), 0);
        cyc(1); chk_st("nolock reset", ST_RESET, 1'b0);
        chk("pulse start", 32'(gt_rst), 1);
        chk("retry one", 32'(retry), 1);
        cyc(3); chk("pulse last", 32'(gt_rst), 1);
        cyc(1); chk("pulse end", 32'(gt_rst), 0);
        chk_st("after pulse", ST_WAIT_GT, 1'b0);
        cyc(10); chk_st("seen_drop blocks", ST_WAIT_GT, 1'b0);
        rx_done = 1'b0;
        cyc(5); chk_st("rx low", ST_WAIT_GT, 1'b0);
        rx_done = 1'b1;
        cyc(2); chk_st("rx back sync", ST_WAIT_GT, 1'b0);
        cyc(1); chk_st("rx back", ST_WAIT_LOCK, 1'b0);
        lock = 1'b1;
        cyc(3); chk_st("relock", ST_UP, 1'b1);
        lock = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1); chk("glitch link_up", 32'(link_up), 1);
        end
        chk("glitch in hold", 32'(state), 32'(ST_DOWN_HOLD));
        lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1); chk("glitch recover link_up", 32'(link_up), 1);
        end
        chk("glitch back up", 32'(state), 32'(ST_UP));
        ber = 1'b1;
        cyc(22); chk_st("ber hold last", ST_DOWN_HOLD, 1'b1);
        cyc(1); chk_st("ber down", ST_WAIT_LOCK, 1'b0);
        cyc(2); ber = 1'b0;
        cyc(3); chk_st("ber clear up", ST_UP, 1'b1);
        rx_done = 1'b0;
        cyc(2); chk_st("rxdrop sync", ST_UP, 1'b1);
        cyc(1); chk_st("rxdrop", ST_WAIT_GT, 1'b0);
        rx_done = 1'b1;
        cyc(3); chk_st("rx return", ST_WAIT_LOCK, 1'b0);
        force_rst = 1'b1;
        cyc(1); force_rst = 1'b0;
        chk_st("force beats lock", ST_RESET, 1'b0);
        chk("force gt_rst", 32'(gt_rst), 1);
        chk("force retry", 32'(retry), 2);
        cyc(4); chk_st("force pulse done", ST_WAIT_GT, 1'b0);
        chk("force pulse end", 32'(gt_rst), 0);
        for (int i = 0; i < 300; i++) begin
            force_rst = 1'b1;
            cyc(1);
            force_rst = 1'b0;
            cyc(1);
            if (i == 9) chk("retry mid", 32'(retry), 12);
        end
        chk("retry saturated", 32'(retry), 255);
        chk_st("forced state", ST_RESET, 1'b0);
        chk("forced pulse", 32'(gt_rst), 1);
        #2 rst = 1'b1;
        #1;
        chk("async gt_rst", 32'(gt_rst), 0);
        chk_st("async rst", ST_WAIT_GT, 1'b0);
        chk("async retry", 32'(retry), 0);
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
